pwm_capture: RTL and testbench
==============================

# pwm_capture

Memory-mapped input-capture peripheral: the measuring counterpart of the I/O block's PWM/CTC timer. It synchronises one external pin, times its high phase and full period in prescaled ticks, and latches both into CPU-readable 16-bit registers. It raises a level interrupt flag per completed period. It sits on the same 8-bit CPU I/O bus as the GPIO/timer block, with address decode to its local window done by the parent.

## Interface
- No parameters.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- din  in  8  bus write data.
- address  in  3  local register index 0–7.
- w_en  in  1  write strobe, one cycle.
- r_en  in  1  read strobe, one cycle.
- dout  out  8  registered read data; reset 0.
- cap_pin  in  1  asynchronous input to be measured.
- cap_flag  out  1  capture-complete interrupt flag; reset 0.
- cap_flag_clr  in  1  interrupt acknowledge; clears cap_flag.

## Operation
- Register map:
  - 0 CTRL: bit0 EN, bit1 IE, bit2 ONESHOT.
  - 1/2 SCALE LSB/MSB.
  - 3/4 WIDTH LSB/MSB (read-only).
  - 5/6 PERIOD LSB/MSB (read-only).
  - 7 STATUS: bit0 cap_flag (read/write), bit1 OVF (write 1 to clear), bit2 BUSY (read-only).
- Writes to read-only registers are ignored. All registers reset to 0.
- Coherent reads: reading 3 (or 5) snapshots the matching MSB into a shadow register; a following read of 4 (or 6) returns the shadow.
- Prescaler: 16-bit counter. `tick` pulses for one clock when prescaler == SCALE, and the prescaler then wraps to 0. SCALE=0 gives a tick every clock.
- Input path: 2-FF synchronizer, then a previous-value register. Rise/fall are detected on the registered pair.
- FSM:
  - IDLE: entered while EN=0; cnt=0. EN=1 → ARM.
  - ARM: wait for a rise; cnt←0 → HIGH.
  - HIGH: cnt counts ticks. On a fall, WIDTH←cnt+tick → LOW.
  - LOW: cnt counts ticks. On a rise, PERIOD←cnt+tick; cnt←0; set cap_flag if IE. Then go to ARM if ONESHOT, otherwise HIGH.
- One counter serves both measurements: it is not reset at the fall, so PERIOD is measured rise-to-rise.
- Overflow: a tick while cnt==FFFFh in HIGH/LOW sets OVF, leaves WIDTH/PERIOD unchanged, → ARM.
- EN cleared in any state → IDLE next cycle. WIDTH/PERIOD keep their values.
- BUSY = state is HIGH or LOW.
- cap_flag priority: cap_flag_clr > STATUS write (din[0]) > capture set.
- OVF priority: write-1 clear > set.

## Timing
- Pin-to-edge latency: 3 clocks, made up of 2 synchronizer stages and the edge register.
- WIDTH/PERIOD update on the clock edge that ends the edge-detect cycle. cap_flag is visible the same cycle as PERIOD.
- Reads: dout is valid the clock after r_en. dout holds its value when r_en=0.
- Writes take effect at the w_en clock edge. A SCALE change applies at the next prescaler compare.
- Pulses shorter than 2 clocks are not guaranteed to be seen.
- Reset mid-measurement: FSM to IDLE; cnt, prescaler, flags and all registers to 0.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE/ARM/HIGH/LOW (2 bits).
  - Register index constants 0–7.
  - CTRL/STATUS bit positions.
- Natural sub-module: `edge_sync`, the 2-FF synchronizer plus rise/fall pulse outputs. It is reusable for the GPIO pins.
- Everything else stays flat in pwm_capture.

## Test plan
- SCALE=0, CTRL=03h, pin high 10 clk / low 30 clk repeating:
  - WIDTH reads 10, PERIOD reads 40.
  - cap_flag rises once per period.
  - cap_flag_clr drops it to 0 the next clock.
- SCALE=3 (tick every 4 clk), pin high 40 clk / low 60 clk → WIDTH=10, PERIOD=25.
- ONESHOT=1: after one capture, BUSY=0 and state is ARM. The next rise restarts the measurement, and PERIOD updates only after a full new cycle.
- SCALE=0, pin held high 70000 clk → OVF=1; WIDTH stays at its previous value. Writing STATUS=02h → OVF reads 0.
- Same-cycle collisions:
  - cap_flag_clr asserted on the capture cycle → cap_flag stays 0.
  - STATUS write din=01h together with cap_flag_clr → cap_flag 0.
- Coherent read with PERIOD=0x1234:
  - Read reg 5 → 34h.
  - A capture then updates PERIOD to 0x5600.
  - Read reg 6 → 12h (shadow), not 56h.
- EN cleared mid-HIGH → BUSY=0 within 1 clk; registers retain their last values.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the pwm_capture input-capture peripheral:
// FSM encoding, local register indices and CTRL/STATUS bit positions.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } cap_state_t;

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_SCALE_L  = 3'd1;
   localparam logic [2:0] REG_SCALE_H  = 3'd2;
   localparam logic [2:0] REG_WIDTH_L  = 3'd3;
   localparam logic [2:0] REG_WIDTH_H  = 3'd4;
   localparam logic [2:0] REG_PERIOD_L = 3'd5;
   localparam logic [2:0] REG_PERIOD_H = 3'd6;
   localparam logic [2:0] REG_STATUS   = 3'd7;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_IE      = 1;
   localparam int CTRL_ONESHOT = 2;

   localparam int STAT_FLAG = 0;
   localparam int STAT_OVF  = 1;
   localparam int STAT_BUSY = 2;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous pin followed by a previous-value
// register; rise/fall are single-cycle pulses on the registered pair.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;

   always_comb begin
      sync1_d = pin;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Input-capture peripheral: times high phase and rise-to-rise period of
// cap_pin in prescaled ticks and exposes them on the 8-bit CPU I/O bus.
//
//   state | meaning
//   IDLE  | EN=0, counter held at zero
//   ARM   | waiting for a rising edge to start a measurement
//   HIGH  | counting the high phase; fall latches WIDTH
//   LOW   | counting the rest of the period; rise latches PERIOD
module pwm_capture (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic [2:0] address,
   input  logic       w_en,
   input  logic       r_en,
   output logic [7:0] dout,
   input  logic       cap_pin,
   output logic       cap_flag,
   input  logic       cap_flag_clr
);
   import pwm_capture_pkg::*;

   cap_state_t  state_q, state_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] scale_q, scale_d;
   logic [15:0] presc_q, presc_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] width_q, width_d;
   logic [15:0] period_q, period_d;
   logic        flag_q, flag_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  dout_q, dout_d;
   logic [7:0]  wshadow_q, wshadow_d;
   logic [7:0]  pshadow_q, pshadow_d;

   logic        rise, fall, tick, en, busy, ovf_hit, cap_set, ovf_set, stat_wr;
   logic [15:0] cnt_inc;
   logic [7:0]  status;

   edge_sync u_edge_sync (
      .clk  (clk),
      .rst  (rst),
      .pin  (cap_pin),
      .rise (rise),
      .fall (fall)
   );

   assign en      = ctrl_q[CTRL_EN];
   assign busy    = (state_q == ST_HIGH) || (state_q == ST_LOW);
   assign tick    = (presc_q == scale_q);
   assign presc_d = tick ? 16'd0 : presc_q + 16'd1;
   assign cnt_inc = cnt_q + {15'd0, tick};
   assign ovf_hit = tick && (cnt_q == 16'hFFFF);
   assign stat_wr = w_en && (address == REG_STATUS);

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM:  if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
               if (ovf_hit)   state_d = ST_ARM;
               else if (fall) state_d = ST_LOW;
            end
            ST_LOW: begin
               if (ovf_hit)   state_d = ST_ARM;
               else if (rise) state_d = ctrl_q[CTRL_ONESHOT] ? ST_ARM : ST_HIGH;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // The counter keeps running through the fall so PERIOD is rise-to-rise.
   always_comb begin
      cnt_d    = cnt_q;
      width_d  = width_q;
      period_d = period_q;
      cap_set  = 1'b0;
      ovf_set  = 1'b0;
      if (!en) begin
         cnt_d = 16'd0;
      end else begin
         case (state_q)
            ST_HIGH: begin
               if (ovf_hit) begin
                  ovf_set = 1'b1;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_inc;
                  if (fall) width_d = cnt_inc;
               end
            end
            ST_LOW: begin
               if (ovf_hit) begin
                  ovf_set = 1'b1;
                  cnt_d   = 16'd0;
               end else if (rise) begin
                  period_d = cnt_inc;
                  cnt_d    = 16'd0;
                  cap_set  = ctrl_q[CTRL_IE];
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: cnt_d = 16'd0;
         endcase
      end
   end

   always_comb begin
      status            = 8'd0;
      status[STAT_FLAG] = flag_q;
      status[STAT_OVF]  = ovf_q;
      status[STAT_BUSY] = busy;

      ctrl_d    = ctrl_q;
      scale_d   = scale_q;
      dout_d    = dout_q;
      wshadow_d = wshadow_q;
      pshadow_d = pshadow_q;

      if (w_en) begin
         case (address)
            REG_CTRL:    ctrl_d         = din[2:0];
            REG_SCALE_L: scale_d[7:0]   = din;
            REG_SCALE_H: scale_d[15:8]  = din;
            default:     ;
         endcase
      end

      if (cap_flag_clr)  flag_d = 1'b0;
      else if (stat_wr)  flag_d = din[STAT_FLAG];
      else if (cap_set)  flag_d = 1'b1;
      else               flag_d = flag_q;

      if (stat_wr && din[STAT_OVF]) ovf_d = 1'b0;
      else if (ovf_set)             ovf_d = 1'b1;
      else                          ovf_d = ovf_q;

      // LSB reads freeze the MSB so a 16-bit value reads back coherently.
      if (r_en) begin
         case (address)
            REG_CTRL:     dout_d = {5'd0, ctrl_q};
            REG_SCALE_L:  dout_d = scale_q[7:0];
            REG_SCALE_H:  dout_d = scale_q[15:8];
            REG_WIDTH_L: begin
               dout_d    = width_q[7:0];
               wshadow_d = width_q[15:8];
            end
            REG_WIDTH_H:  dout_d = wshadow_q;
            REG_PERIOD_L: begin
               dout_d    = period_q[7:0];
               pshadow_d = period_q[15:8];
            end
            REG_PERIOD_H: dout_d = pshadow_q;
            default:      dout_d = status;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= 3'd0;
         scale_q   <= 16'd0;
         presc_q   <= 16'd0;
         cnt_q     <= 16'd0;
         width_q   <= 16'd0;
         period_q  <= 16'd0;
         flag_q    <= 1'b0;
         ovf_q     <= 1'b0;
         dout_q    <= 8'd0;
         wshadow_q <= 8'd0;
         pshadow_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         scale_q   <= scale_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         width_q   <= width_d;
         period_q  <= period_d;
         flag_q    <= flag_d;
         ovf_q     <= ovf_d;
         dout_q    <= dout_d;
         wshadow_q <= wshadow_d;
         pshadow_q <= pshadow_d;
      end
   end

   assign dout     = dout_q;
   assign cap_flag = flag_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares on every read response or probe.
module tb_pwm_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic [2:0] address;
   logic       w_en;
   logic       r_en;
   logic [7:0] dout;
   logic       cap_pin;
   logic       cap_flag;
   logic       cap_flag_clr;

   pwm_capture dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .address      (address),
      .w_en         (w_en),
      .r_en         (r_en),
      .dout         (dout),
      .cap_pin      (cap_pin),
      .cap_flag     (cap_flag),
      .cap_flag_clr (cap_flag_clr)
   );

   always #5 clk = ~clk;

   // kind: 0 = dout, 1 = cap_flag, 3 = cap_flag rise count, 4 = pending expectations
   typedef struct {
      int          kind;
      logic [7:0]  val;
      logic [95:0] name;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       rd_seen = 1'b0;
   logic       probe = 1'b0;
   logic [7:0] rise_cnt = 8'd0;
   logic       flag_prev = 1'b0;
   logic [7:0] base;

   always @(posedge clk) rd_seen <= r_en;

   always @(negedge clk) begin
      if (cap_flag === 1'b1 && flag_prev !== 1'b1) rise_cnt <= rise_cnt + 8'd1;
      flag_prev <= cap_flag;
   end

   task automatic check_one();
      exp_t       e;
      logic [7:0] act;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_sample: got dout=%02h, required no sample", dout);
      end else begin
         e = exp_q.pop_front();
         case (e.kind)
            1:       act = {7'd0, cap_flag};
            3:       act = rise_cnt;
            4:       act = 8'(exp_q.size());
            default: act = dout;
         endcase
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %0s: got %02h, required %02h", e.name, act, e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rd_seen) check_one();
      if (probe) check_one();
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(int kind, logic [7:0] v, logic [95:0] nm);
      exp_t e;
      e.kind = kind;
      e.val  = v;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic rd(logic [2:0] a, logic [7:0] v, logic [95:0] nm);
      push_exp(0, v, nm);
      address = a;
      r_en    = 1'b1;
      cyc(1);
      r_en    = 1'b0;
   endtask

   task automatic wr(logic [2:0] a, logic [7:0] d);
      address = a;
      din     = d;
      w_en    = 1'b1;
      cyc(1);
      w_en    = 1'b0;
   endtask

   task automatic probe_k(int kind, logic [7:0] v, logic [95:0] nm);
      push_exp(kind, v, nm);
      probe = 1'b1;
      cyc(1);
      probe = 1'b0;
   endtask

   task automatic clr_pulse();
      cap_flag_clr = 1'b1;
      cyc(1);
      cap_flag_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; din = 8'd0; address = 3'd0; w_en = 1'b0; r_en = 1'b0;
      cap_pin = 1'b0; cap_flag_clr = 1'b0;
      cyc(3);
      rst = 1'b0;
      probe_k(0, 8'h00, "reset_dout");
      probe_k(1, 8'h00, "reset_flag");
      rd(3'd7, 8'h00, "reset_stat");
      rd(3'd0, 8'h00, "reset_ctrl");

      // SCALE=0, 10 high / 30 low
      wr(3'd0, 8'h03);
      base = rise_cnt;
      for (int i = 0; i < 4; i++) begin
         cap_pin = 1'b1;
         cyc(6);
         probe_k(1, (i > 0) ? 8'h01 : 8'h00, "t1_flag_set");
         clr_pulse();
         probe_k(1, 8'h00, "t1_flag_clr");
         cyc(1);
         cap_pin = 1'b0;
         cyc(30);
      end
      probe_k(3, base + 8'd3, "t1_rises");
      rd(3'd3, 8'h0A, "t1_width_l");
      rd(3'd4, 8'h00, "t1_width_h");
      rd(3'd5, 8'h28, "t1_period_l");
      rd(3'd6, 8'h00, "t1_period_h");

      // SCALE=3, 40 high / 60 low
      wr(3'd0, 8'h00);
      wr(3'd1, 8'h03);
      wr(3'd0, 8'h03);
      for (int i = 0; i < 3; i++) begin
         cap_pin = 1'b1;
         cyc(40);
         cap_pin = 1'b0;
         cyc(60);
      end
      rd(3'd3, 8'h0A, "t2_width_l");
      rd(3'd4, 8'h00, "t2_width_h");
      rd(3'd5, 8'h19, "t2_period_l");
      rd(3'd6, 8'h00, "t2_period_h");
      rd(3'd1, 8'h03, "t2_scale_l");
      rd(3'd0, 8'h03, "t2_ctrl");

      // reset in the middle of a measurement
      cap_pin = 1'b1;
      cyc(5);
      rst = 1'b1;
      cap_pin = 1'b0;
      cyc(2);
      rst = 1'b0;
      rd(3'd3, 8'h00, "rst_width");
      rd(3'd5, 8'h00, "rst_period");
      rd(3'd7, 8'h00, "rst_status");
      rd(3'd1, 8'h00, "rst_scale");
      probe_k(1, 8'h00, "rst_flag");

      // ONESHOT
      wr(3'd0, 8'h07);
      cap_pin = 1'b1; cyc(10);
      cap_pin = 1'b0; cyc(20);
      cap_pin = 1'b1; cyc(4);
      rd(3'd7, 8'h01, "os_idle_stat");
      cyc(3);
      cap_pin = 1'b0; cyc(12);
      cap_pin = 1'b1; cyc(5);
      cap_pin = 1'b0; cyc(4);
      rd(3'd7, 8'h05, "os_busy_stat");
      rd(3'd5, 8'h1E, "os_per_hold");
      cyc(9);
      cap_pin = 1'b1; cyc(6);
      rd(3'd5, 8'h14, "os_period");
      rd(3'd3, 8'h05, "os_width");
      clr_pulse();
      probe_k(1, 8'h00, "os_flag_clr");

      // same-cycle collisions on cap_flag
      wr(3'd0, 8'h03);
      cap_pin = 1'b0; cyc(10);
      cap_pin = 1'b1; cyc(10);
      cap_pin = 1'b0; cyc(10);
      cap_pin = 1'b1; cyc(2);
      clr_pulse();
      probe_k(1, 8'h00, "clr_vs_cap");
      rd(3'd5, 8'h14, "col_period");
      rd(3'd3, 8'h0A, "col_width");
      wr(3'd7, 8'h01);
      probe_k(1, 8'h01, "stat_wr_flag");
      address = 3'd7; din = 8'h01; w_en = 1'b1; cap_flag_clr = 1'b1;
      cyc(1);
      w_en = 1'b0; cap_flag_clr = 1'b0;
      probe_k(1, 8'h00, "clr_vs_wr");

      // EN cleared mid-HIGH
      rd(3'd7, 8'h04, "en_busy");
      wr(3'd0, 8'h02);
      cyc(1);
      rd(3'd7, 8'h00, "en_off_stat");
      rd(3'd3, 8'h0A, "en_off_width");
      rd(3'd5, 8'h14, "en_off_per");
      rd(3'd0, 8'h02, "en_off_ctrl");

      // overflow while held high
      wr(3'd0, 8'h03);
      cap_pin = 1'b0; cyc(5);
      cap_pin = 1'b1; cyc(65545);
      rd(3'd7, 8'h02, "ovf_stat");
      rd(3'd3, 8'h0A, "ovf_width");
      wr(3'd7, 8'h02);
      rd(3'd7, 8'h00, "ovf_clr_stat");

      // coherent PERIOD read across a capture
      cap_pin = 1'b0; cyc(10);
      cap_pin = 1'b1; cyc(100);
      cap_pin = 1'b0; cyc(4560);
      cap_pin = 1'b1; cyc(5);
      rd(3'd5, 8'h34, "coh_per_l");
      cyc(94);
      cap_pin = 1'b0; cyc(21916);
      cap_pin = 1'b1; cyc(5);
      rd(3'd6, 8'h12, "coh_shadow");
      rd(3'd5, 8'h00, "coh_new_l");
      rd(3'd6, 8'h56, "coh_new_h");
      wr(3'd3, 8'hFF);
      rd(3'd4, 8'h00, "ro_width_h");
      rd(3'd3, 8'h64, "ro_width_l");
      cyc(3);
      probe_k(0, 8'h64, "dout_hold");

      probe_k(4, 8'h00, "pending");
      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
